// File: rtl/adc_responder.sv
// -----------------------------------------------------------------------------
// adc_responder
//
// Purpose:
//   Emulates an 8-channel, 8-bit parallel-output ADC for the sampler front end.
//   A falling n_convst starts a conversion. After CONV_CYCLES clocks, n_eoc
//   goes low. A read strobe (n_cs and n_rd both low) then puts the sample on
//   the bus. Each channel's sample comes from an internal free-running ramp
//   plus a per-channel phase offset. This gives a known, deterministic
//   waveform without the analog board.
//
// Ports:
//   clk          in   1  system clock (shared with the sampler)
//   reset        in   1  synchronous, active-high reset
//   chnl         in   3  channel select, sampled at conversion start
//   n_convst     in   1  start conversion, active low
//   n_cs         in   1  chip select, active low
//   n_rd         in   1  read strobe, active low
//   n_eoc        out  1  end of conversion, active low
//   adc_data     out  8  sample bus (0 when not driven)
//   data_oe      out  1  high while the bus is driven
//   ramp_en      in   1  1 = ramp advances, 0 = ramp and divider frozen
//   overrun      out  1  sticky: a conversion was restarted or ignored
//   overrun_clr  in   1  clears overrun; wins over a same-cycle set
//   conv_count   out 16  completed conversions, wraps
// -----------------------------------------------------------------------------
module adc_responder #(
    parameter int CONV_CYCLES = 8,
    parameter int RAMP_DIV    = 64,
    parameter int PHASE_STEP  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  chnl,
    input  logic        n_convst,
    input  logic        n_cs,
    input  logic        n_rd,
    output logic        n_eoc,
    output logic [7:0]  adc_data,
    output logic        data_oe,
    input  logic        ramp_en,
    output logic        overrun,
    input  logic        overrun_clr,
    output logic [15:0] conv_count
);

    localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        EOC  = 2'd2,
        READ = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Registered strobes: cur is the first register stage, prev is the
    // second. Edges are detected between them.
    logic r_convst_cur, r_convst_prev;
    logic r_cs_cur, r_cs_prev;
    logic r_rd_cur, r_rd_prev;

    logic [CNT_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [7:0]       r_ramp;
    logic [7:0]       r_ramp_snap;   // ramp value captured at conversion start
    logic [2:0]       r_chnl;        // channel captured at conversion start
    logic [15:0]      r_conv_count;
    logic             r_overrun;

    logic w_convst_fall;
    logic w_cs_rise;
    logic w_rd_rise;
    logic w_start;      // latch channel/ramp and load the conversion counter
    logic w_done;       // conversion finished this cycle
    logic w_ovr_set;
    logic w_in_result;  // state holds a valid, readable result
    logic [7:0] w_sample;

    // Per-channel phase offsets, reduced mod 256 at elaboration time.
    logic [7:0] w_phase_tab [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_phase
            assign w_phase_tab[gi] = 8'((gi * PHASE_STEP) % 256);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Input registers
    // -------------------------------------------------------------------------
    // Reset to the inactive level so that releasing reset cannot fake an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_convst_cur  <= 1'b1;
            r_convst_prev <= 1'b1;
            r_cs_cur      <= 1'b1;
            r_cs_prev     <= 1'b1;
            r_rd_cur      <= 1'b1;
            r_rd_prev     <= 1'b1;
        end else begin
            r_convst_cur  <= n_convst;
            r_convst_prev <= r_convst_cur;
            r_cs_cur      <= n_cs;
            r_cs_prev     <= r_cs_cur;
            r_rd_cur      <= n_rd;
            r_rd_prev     <= r_rd_cur;
        end
    end

    assign w_convst_fall = r_convst_prev & ~r_convst_cur;
    assign w_cs_rise     = ~r_cs_prev & r_cs_cur;
    assign w_rd_rise     = ~r_rd_prev & r_rd_cur;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_done       = 1'b0;
        w_ovr_set    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_convst_fall) begin
                    w_start      = 1'b1;
                    w_state_next = CONV;
                end
            end
            CONV: begin
                // A second start in progress is dropped, but it is flagged.
                if (w_convst_fall) begin
                    w_ovr_set = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_done       = 1'b1;
                    w_state_next = EOC;
                end
            end
            EOC: begin
                // Restart beats a read that arrives in the same cycle.
                if (w_convst_fall) begin
                    w_ovr_set    = 1'b1;
                    w_start      = 1'b1;
                    w_state_next = CONV;
                end else if (!r_cs_cur && !r_rd_cur) begin
                    w_state_next = READ;
                end
            end
            READ: begin
                if (w_convst_fall) begin
                    w_ovr_set    = 1'b1;
                    w_start      = 1'b1;
                    w_state_next = CONV;
                end else if (w_rd_rise || w_cs_rise) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    // The bus follows the raw strobes combinationally. This lets a read
    // window as short as two clocks see valid data in the cycle it opens.
    always_comb begin
        w_in_result = (r_state == EOC) || (r_state == READ);
        n_eoc       = ~w_in_result;
        data_oe     = ~n_cs & ~n_rd & w_in_result;
        adc_data    = data_oe ? w_sample : 8'h00;
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_chnl       <= 3'd0;
            r_ramp_snap  <= 8'h00;
            r_conv_count <= 16'd0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt       <= CNT_W'(CONV_CYCLES - 1);
                r_chnl      <= chnl;
                r_ramp_snap <= r_ramp;
            end else if (r_state == CONV && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_done) begin
                r_conv_count <= r_conv_count + 16'd1;
            end

            if (overrun_clr) begin
                r_overrun <= 1'b0;
            end else if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign w_sample   = r_ramp_snap + w_phase_tab[r_chnl];
    assign overrun    = r_overrun;
    assign conv_count = r_conv_count;

    // -------------------------------------------------------------------------
    // Ramp generator: one step every RAMP_DIV enabled clocks
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div  <= '0;
            r_ramp <= 8'h00;
        end else if (ramp_en) begin
            if (r_div == DIV_W'(RAMP_DIV - 1)) begin
                r_div  <= '0;
                r_ramp <= r_ramp + 8'd1;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_responder.sv
module tb_adc_responder;

    logic        clk;
    logic        reset;
    logic [2:0]  chnl;
    logic        n_convst;
    logic        n_cs;
    logic        n_rd;
    logic        n_eoc;
    logic [7:0]  adc_data;
    logic        data_oe;
    logic        ramp_en;
    logic        overrun;
    logic        overrun_clr;
    logic [15:0] conv_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    adc_responder dut (
        .clk         (clk),
        .reset       (reset),
        .chnl        (chnl),
        .n_convst    (n_convst),
        .n_cs        (n_cs),
        .n_rd        (n_rd),
        .n_eoc       (n_eoc),
        .adc_data    (adc_data),
        .data_oe     (data_oe),
        .ramp_en     (ramp_en),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .conv_count  (conv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse n_convst for one clock and wait for n_eoc, checking the latency
    // counted in clocks from the raw falling edge.
    task automatic convert(input logic [2:0] ch, input string tag);
        int c;
        chnl     = ch;
        n_convst = 1'b0;
        tick();
        c = 1;
        n_convst = 1'b1;
        while (n_eoc === 1'b1 && c < 40) begin
            tick();
            c++;
        end
        check({tag, "_latency"}, c, 10);
    endtask

    // Read strobe sequence with the result bus checked in the opening cycle.
    task automatic do_read(input logic [7:0] exp, input string tag, input bit quiet);
        n_cs = 1'b0;
        #1;
        check({tag, "_oe_cs_only"}, data_oe, 1'b0);
        n_rd = 1'b0;
        #1;
        check({tag, "_oe"}, data_oe, 1'b1);
        check({tag, "_data"}, adc_data, exp);
        if (!quiet) $display("[TB] read %s data=0x%02h oe=%0b", tag, adc_data, data_oe);
        tick();
        tick();
        check({tag, "_eoc_in_read"}, n_eoc, 1'b0);
        n_rd = 1'b1;
        n_cs = 1'b1;
        tick();
        check({tag, "_eoc_hold"}, n_eoc, 1'b0);
        tick();
        check({tag, "_eoc_release"}, n_eoc, 1'b1);
        check({tag, "_oe_off"}, data_oe, 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        chnl        = 3'd0;
        n_convst    = 1'b1;
        n_cs        = 1'b1;
        n_rd        = 1'b1;
        ramp_en     = 1'b0;
        overrun_clr = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_n_eoc", n_eoc, 1'b1);
        check("rst_data_oe", data_oe, 1'b0);
        check("rst_adc_data", adc_data, 8'h00);
        check("rst_overrun", overrun, 1'b0);
        check("rst_conv_count", conv_count, 16'd0);

        // Strobes in IDLE: no bus drive, no state change
        n_cs = 1'b0;
        n_rd = 1'b0;
        #1;
        check("idle_strobe_oe", data_oe, 1'b0);
        check("idle_strobe_data", adc_data, 8'h00);
        repeat (3) tick();
        check("idle_strobe_eoc", n_eoc, 1'b1);
        n_cs = 1'b1;
        n_rd = 1'b1;
        tick();
        tick();
        $display("[TB] idle strobe n_eoc=%0b oe=%0b", n_eoc, data_oe);

        // Basic conversion, ramp frozen at 0, channel 3
        convert(3'd3, "conv_ch3");
        do_read(8'h30, "conv_ch3", 1'b0);
        check("conv_ch3_count", conv_count, 16'd1);

        // Second start 3 clocks into CONV is ignored but flagged
        chnl     = 3'd4;
        n_convst = 1'b0;
        tick();
        cyc = 1;
        n_convst = 1'b1;
        tick();
        tick();
        tick();
        cyc += 3;
        chnl     = 3'd6;
        n_convst = 1'b0;
        tick();
        cyc++;
        n_convst = 1'b1;
        while (n_eoc === 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("ignored_latency", cyc, 10);
        check("ignored_overrun", overrun, 1'b1);
        check("ignored_count", conv_count, 16'd2);
        do_read(8'h40, "ignored_ch4", 1'b0);
        check("ignored_count_after", conv_count, 16'd2);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clear", overrun, 1'b0);
        $display("[TB] overrun cleared overrun=%0b", overrun);

        // Restart with unread data
        convert(3'd2, "unread_pre");
        check("unread_pre_count", conv_count, 16'd3);
        chnl     = 3'd5;
        n_convst = 1'b0;
        tick();
        cyc = 1;
        n_convst = 1'b1;
        tick();
        cyc++;
        check("restart_eoc_high", n_eoc, 1'b1);
        check("restart_overrun", overrun, 1'b1);
        while (n_eoc === 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("restart_latency", cyc, 10);
        do_read(8'h50, "restart_ch5", 1'b0);
        check("restart_count", conv_count, 16'd4);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clear2", overrun, 1'b0);

        // Clear in the same cycle as a restart set: clear wins
        convert(3'd1, "clrprio_pre");
        n_convst = 1'b0;
        tick();
        cyc = 1;
        n_convst    = 1'b1;
        overrun_clr = 1'b1;
        tick();
        cyc++;
        overrun_clr = 1'b0;
        check("clrprio_same_cycle", overrun, 1'b0);
        tick();
        cyc++;
        check("clrprio_after", overrun, 1'b0);
        while (n_eoc === 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("clrprio_latency", cyc, 10);
        do_read(8'h10, "clrprio_ch1", 1'b0);
        check("clrprio_count", conv_count, 16'd6);

        // Ramp advanced 5 steps, channel 7
        ramp_en = 1'b1;
        repeat (64 * 5) tick();
        ramp_en = 1'b0;
        repeat (3) tick();
        convert(3'd7, "ramp5_ch7");
        do_read(8'h75, "ramp5_ch7", 1'b0);
        check("ramp5_count", conv_count, 16'd7);

        // Reset during CONV drops the conversion
        chnl     = 3'd6;
        n_convst = 1'b0;
        tick();
        n_convst = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_eoc", n_eoc, 1'b1);
        check("midrst_count", conv_count, 16'd0);
        repeat (12) tick();
        check("midrst_eoc_later", n_eoc, 1'b1);
        check("midrst_count_later", conv_count, 16'd0);
        $display("[TB] reset during conversion n_eoc=%0b count=%0d", n_eoc, conv_count);
        convert(3'd3, "postrst_ch3");
        do_read(8'h30, "postrst_ch3", 1'b0);
        check("postrst_count", conv_count, 16'd1);

        // Ramp at 250, channel 1 wraps to 0x0A
        ramp_en = 1'b1;
        repeat (64 * 250) tick();
        ramp_en = 1'b0;
        convert(3'd1, "ramp250_ch1");
        do_read(8'h0A, "ramp250_ch1", 1'b0);

        // Sampler-style loop: ramp frozen at 0x20, 64 frames of ch0..ch3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ramp_en = 1'b1;
        repeat (64 * 32) tick();
        ramp_en = 1'b0;
        for (int f = 0; f < 64; f++) begin
            for (int c = 0; c < 4; c++) begin
                logic [7:0] exp_v;
                exp_v = 8'h20 + 8'(c * 16);
                convert(3'(c), $sformatf("frame%0d_ch%0d", f, c));
                do_read(exp_v, $sformatf("frame%0d_ch%0d", f, c), 1'b1);
            end
            $display("[TB] frame %0d done count=%0d overrun=%0b", f, conv_count, overrun);
        end
        check("sampler_overrun", overrun, 1'b0);
        check("sampler_count", conv_count, 16'd256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
